// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake and synchronous flush.
// SKID=1 adds a second entry, so upstream ready comes straight from a flop.
module pipe_stage_reg #(
  parameter int WIDTH = 64,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic             r_main_vld;
  logic [WIDTH-1:0] r_main_data;
  logic             w_in_fire;
  logic             w_out_fire;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_main_vld & out_ready;
  assign out_valid  = r_main_vld;
  assign out_data   = r_main_data;

  generate
    if (SKID == 0) begin : g_single
      // Ready looks through to downstream so a full stage can still stream.
      assign in_ready = !r_main_vld | out_ready;
      assign count    = {1'b0, r_main_vld};

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_main_vld  <= 1'b0;
          r_main_data <= '0;
        end else if (flush) begin
          r_main_vld  <= 1'b0;
          r_main_data <= '0;
        end else if (w_in_fire) begin
          r_main_vld  <= 1'b1;
          r_main_data <= in_data;
        end else if (w_out_fire) begin
          r_main_vld  <= 1'b0;
          r_main_data <= '0;
        end
      end
    end else begin : g_skid
      logic             r_skid_vld;
      logic [WIDTH-1:0] r_skid_data;

      // Skid is only ever occupied while main is, so a free skid means room.
      assign in_ready = !r_skid_vld;
      assign count    = {1'b0, r_main_vld} + {1'b0, r_skid_vld};

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_main_vld  <= 1'b0;
          r_main_data <= '0;
          r_skid_vld  <= 1'b0;
          r_skid_data <= '0;
        end else if (flush) begin
          r_main_vld  <= 1'b0;
          r_main_data <= '0;
          r_skid_vld  <= 1'b0;
          r_skid_data <= '0;
        end else if (!r_main_vld) begin
          if (w_in_fire) begin
            r_main_vld  <= 1'b1;
            r_main_data <= in_data;
          end
        end else if (w_out_fire) begin
          if (r_skid_vld) begin
            r_main_data <= r_skid_data;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
          end else if (w_in_fire) begin
            r_main_data <= in_data;
          end else begin
            r_main_vld  <= 1'b0;
            r_main_data <= '0;
          end
        end else if (w_in_fire) begin
          r_skid_vld  <= 1'b1;
          r_skid_data <= in_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance,
// each compared against a FIFO-of-accepted-payloads reference.
module tb_pipe_stage_reg;

  logic        clk;
  logic        resetn;
  logic        flush     [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_data   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_data  [2];
  logic [1:0]  cnt       [2];

  logic [31:0] q [2][$];
  int          delivered [2];
  logic [31:0] last_out  [2];
  logic        fired     [2];
  int          n_tests;
  int          n_fail;

  pipe_stage_reg #(.WIDTH(32), .SKID(0)) u_dut0 (
    .clk(clk), .resetn(resetn), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .count(cnt[0]));

  pipe_stage_reg #(.WIDTH(32), .SKID(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .count(cnt[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int k, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, got, exp, $time);
    end
  endtask

  // Monitor: the model holds every accepted, undelivered, unflushed payload.
  initial forever begin
    @(negedge clk);
    #1;
    if (resetn) begin
      for (int k = 0; k < 2; k++) begin
        automatic int sz = q[k].size();
        automatic logic exp_rdy = (k == 1) ? (sz < 2) : (sz == 0 || out_ready[k]);
        automatic logic [31:0] exp_d;
        check("count", k, 64'(cnt[k]), 64'(sz));
        check("out_valid", k, 64'(out_valid[k]), 64'(sz > 0));
        check("in_ready", k, 64'(in_ready[k]), 64'(exp_rdy));
        if (!out_valid[k]) begin
          check("bubble_zero", k, 64'(out_data[k]), 64'd0);
        end else if (out_ready[k] && sz > 0) begin
          exp_d = q[k].pop_front();
          check("out_data", k, 64'(out_data[k]), 64'(exp_d));
          delivered[k]++;
          last_out[k] = out_data[k];
        end
      end
    end
  end

  // Stimulus side of the scoreboard: record accepted payloads, apply flush.
  initial forever begin
    @(negedge clk);
    #2;
    if (resetn) begin
      for (int k = 0; k < 2; k++) begin
        if (in_valid[k] && in_ready[k]) fired[k] = 1'b1;
        if (flush[k]) q[k].delete();
        else if (in_valid[k] && in_ready[k]) q[k].push_back(in_data[k]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int k, input logic [31:0] d);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (in_ready[k]) begin
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_data[k]  = '0;
        return;
      end
      @(negedge clk);
    end
    check("send_timeout", k, 64'd0, 64'd1);
    in_valid[k] = 1'b0;
  endtask

  initial begin
    int d0;
    n_tests = 0;
    n_fail  = 0;
    resetn  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      flush[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b0;
      delivered[k] = 0; last_out[k] = '0; fired[k] = 1'b0;
    end
    #2;
    for (int k = 0; k < 2; k++) begin
      check("rst_out_valid", k, 64'(out_valid[k]), 64'd0);
      check("rst_out_data", k, 64'(out_data[k]), 64'd0);
      check("rst_count", k, 64'(cnt[k]), 64'd0);
      check("rst_in_ready", k, 64'(in_ready[k]), 64'd1);
    end
    @(negedge clk);
    resetn = 1'b1;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;

    // Back-to-back streaming through the skid stage
    d0 = delivered[1];
    for (int i = 1; i <= 16; i++) send(1, 32'(i));
    repeat (3) @(negedge clk);
    check("stream_delivered", 1, 64'(delivered[1] - d0), 64'd16);
    check("stream_last", 1, 64'(last_out[1]), 64'h10);

    // Back-pressure fills main and skid; C waits for ready to return
    out_ready[1] = 1'b0;
    d0 = delivered[1];
    send(1, 32'hA);
    send(1, 32'hB);
    #1;
    check("bp_count", 1, 64'(cnt[1]), 64'd2);
    check("bp_in_ready", 1, 64'(in_ready[1]), 64'd0);
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_data[1]  = 32'hC;
    repeat (2) @(negedge clk);
    out_ready[1] = 1'b1;
    send(1, 32'hC);
    repeat (4) @(negedge clk);
    check("bp_delivered", 1, 64'(delivered[1] - d0), 64'd3);
    check("bp_last", 1, 64'(last_out[1]), 64'hC);

    // Flush wins over a same-cycle in_fire
    out_ready[1] = 1'b0;
    d0 = delivered[1];
    send(1, 32'h11);
    flush[1] = 1'b1; in_valid[1] = 1'b1; in_data[1] = 32'hD;
    @(negedge clk);
    flush[1] = 1'b0; in_valid[1] = 1'b0;
    #1;
    check("fl1_count", 1, 64'(cnt[1]), 64'd0);
    check("fl1_out_valid", 1, 64'(out_valid[1]), 64'd0);
    check("fl1_out_data", 1, 64'(out_data[1]), 64'd0);
    check("fl1_in_ready", 1, 64'(in_ready[1]), 64'd1);
    @(negedge clk);
    send(1, 32'h12);
    send(1, 32'h13);
    flush[1] = 1'b1; in_valid[1] = 1'b1; in_data[1] = 32'hD;
    @(negedge clk);
    flush[1] = 1'b0; in_valid[1] = 1'b0;
    #1;
    check("fl2_count", 1, 64'(cnt[1]), 64'd0);
    check("fl2_out_valid", 1, 64'(out_valid[1]), 64'd0);
    check("fl2_in_ready", 1, 64'(in_ready[1]), 64'd1);
    @(negedge clk);
    out_ready[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("fl_nothing_out", 1, 64'(delivered[1] - d0), 64'd0);

    // SKID=0: ready follows out_ready combinationally when full
    out_ready[0] = 1'b0;
    send(0, 32'h21);
    #1;
    check("s0_stall_ready", 0, 64'(in_ready[0]), 64'd0);
    @(negedge clk);
    out_ready[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 32'h22;
    #1;
    check("s0_comb_ready", 0, 64'(in_ready[0]), 64'd1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    #1;
    check("s0_next_valid", 0, 64'(out_valid[0]), 64'd1);
    check("s0_next_data", 0, 64'(out_data[0]), 64'h22);
    @(negedge clk);

    // Asynchronous reset with two entries held
    out_ready[1] = 1'b0;
    send(1, 32'h31);
    send(1, 32'h32);
    #3;
    resetn = 1'b0;
    q[0].delete();
    q[1].delete();
    #1;
    check("ar_out_valid", 1, 64'(out_valid[1]), 64'd0);
    check("ar_out_data", 1, 64'(out_data[1]), 64'd0);
    check("ar_count", 1, 64'(cnt[1]), 64'd0);
    check("ar_in_ready", 1, 64'(in_ready[1]), 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    out_ready[1] = 1'b1;
    in_valid[1] = 1'b1; in_data[1] = 32'h33;
    #1;
    check("ar_accept_ready", 1, 64'(in_ready[1]), 64'd1);
    @(negedge clk);
    in_valid[1] = 1'b0;
    #1;
    check("ar_first_data", 1, 64'(out_data[1]), 64'h33);

    // Random valid/ready/flush on both instances
    @(negedge clk);
    fired[0] = 1'b0;
    fired[1] = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!in_valid[k] || fired[k]) begin
          in_valid[k] = ($urandom % 4) != 0;
          in_data[k]  = $urandom;
        end
        fired[k]     = 1'b0;
        out_ready[k] = ($urandom % 4) != 0;
        flush[k]     = ($urandom % 20) == 0;
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; flush[k] = 1'b0; out_ready[k] = 1'b1;
    end
    repeat (5) @(negedge clk);
    #3;
    for (int k = 0; k < 2; k++) begin
      check("drain_model", k, 64'(q[k].size()), 64'd0);
      check("drain_count", k, 64'(cnt[k]), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
